// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract unit.
package digit_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic bit params_ok(input int width, input int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Start/Busy/Done handshake plus operand and result bus of the digit-serial adder.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             Start;
    logic             Sub;
    logic             Cin;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Sub, Cin, X, Y,
        input  S, Cout, Overflow, Busy, Done
    );

    modport slave (
        input  Start, Sub, Cin, X, Y,
        output S, Cout, Overflow, Busy, Done
    );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple slice: one digit of A plus B' plus incoming carry.
module digit_serial_adder_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic             Cin,
    input  logic [DIGIT-1:0] X,
    input  logic [DIGIT-1:0] Y,
    output logic [DIGIT-1:0] S,
    output logic             Cout
);
    logic [DIGIT:0] sum_s;

    assign sum_s = {1'b0, X} + {1'b0, Y} + {{DIGIT{1'b0}}, Cin};
    assign S     = sum_s[DIGIT-1:0];
    assign Cout  = sum_s[DIGIT];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice per cycle, LSB digit first,
// carry held in a register between digits, Start/Busy/Done handshake.
module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    digit_serial_adder_if.slave  bus
);
    localparam int             N    = digit_count(WIDTH, DIGIT);
    localparam int             CW   = $clog2(N + 1);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    generate
        if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
            $fatal(1, "digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_sum_s;
    logic             dig_cout_s;
    logic [WIDTH-1:0] part_next_s;
    logic [WIDTH-1:0] b_in_s;

    digit_serial_adder_digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .Cin  (carry_q),
        .X    (a_q[DIGIT-1:0]),
        .Y    (b_q[DIGIT-1:0]),
        .S    (dig_sum_s),
        .Cout (dig_cout_s)
    );

    // New sum digit enters at the MSB end; after N shifts digit 0 sits at the LSB.
    assign part_next_s = (WIDTH'(dig_sum_s) << (WIDTH - DIGIT)) | (part_q >> DIGIT);
    assign b_in_s      = bus.Y ^ {WIDTH{bus.Sub}};

    // Next-state, datapath and output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.Start) begin
                    a_d     = bus.X;
                    b_d     = b_in_s;
                    a_msb_d = bus.X[WIDTH-1];
                    b_msb_d = b_in_s[WIDTH-1];
                    carry_d = bus.Sub ? 1'b1 : bus.Cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                part_d  = part_next_s;
                carry_d = dig_cout_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    s_d     = part_next_s;
                    cout_d  = dig_cout_s;
                    ovf_d   = (a_msb_q == b_msb_q) && (part_next_s[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.S        = s_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: three adders (DIGIT=4, 1, 16 at WIDTH=16) against a signed/unsigned arithmetic model.
module tb_digit_serial_adder;

    typedef struct {
        logic        sub;
        logic        cin;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_v   [3];
    logic        start_v [3];
    logic        sub_v   [3];
    logic        cin_v   [3];
    logic [15:0] x_v     [3];
    logic [15:0] y_v     [3];
    logic [15:0] s_a     [3];
    logic        cout_a  [3];
    logic        ovf_a   [3];
    logic        busy_a  [3];
    logic        done_a  [3];

    int n_vec = 0;
    int n_err = 0;
    int nd [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIG = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
        digit_serial_adder_if #(.WIDTH(16)) ifc ();
        assign ifc.Start = start_v[g];
        assign ifc.Sub   = sub_v[g];
        assign ifc.Cin   = cin_v[g];
        assign ifc.X     = x_v[g];
        assign ifc.Y     = y_v[g];
        assign s_a[g]    = ifc.S;
        assign cout_a[g] = ifc.Cout;
        assign ovf_a[g]  = ifc.Overflow;
        assign busy_a[g] = ifc.Busy;
        assign done_a[g] = ifc.Done;
        digit_serial_adder #(.WIDTH(16), .DIGIT(DIG)) u_dut (
            .Clock (clk),
            .Reset (rst_v[g]),
            .bus   (ifc.slave)
        );
    end

    function automatic res_t model(input logic sub, input logic cin, input logic [15:0] x, input logic [15:0] y);
        res_t r;
        int ux, uy, sx, sy, tot, st;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!sub) begin
            tot    = ux + uy + int'(cin);
            r.cout = (tot > 65535);
            st     = sx + sy + int'(cin);
        end else begin
            tot    = ux - uy;
            r.cout = (ux >= uy);
            st     = sx - sy;
        end
        r.s   = 16'(tot);
        r.ovf = (st > 32767) || (st < -32768);
        return r;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
        end
    endtask

    // One operation; with disturb, operands change and Start re-pulses while busy.
    task automatic do_op(input int d, input logic sub, input logic cin, input logic [15:0] x,
                         input logic [15:0] y, input bit disturb, input res_t e);
        int m;
        int busy_n = 0;
        bit seen = 0;
        @(negedge clk);
        sub_v[d] = sub; cin_v[d] = cin; x_v[d] = x; y_v[d] = y; start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[d] = 1'b0;
        if (disturb) begin
            x_v[d] = ~x; y_v[d] = x ^ y; sub_v[d] = ~sub; cin_v[d] = ~cin;
        end
        for (m = 0; m < 100; m++) begin
            if (disturb && m == 1 && nd[d] > 2) start_v[d] = 1'b1;
            if (m == 2) start_v[d] = 1'b0;
            if (done_a[d]) begin
                seen = 1;
                break;
            end
            if (busy_a[d]) busy_n++;
            @(negedge clk);
        end
        check("done_seen", d, 32'(seen), 32'd1);
        check("latency", d, 32'(m), 32'(nd[d]));
        check("busy_cycles", d, 32'(busy_n), 32'(nd[d]));
        check("busy_at_done", d, 32'(busy_a[d]), 32'd0);
        check("S", d, 32'(s_a[d]), 32'(e.s));
        check("Cout", d, 32'(cout_a[d]), 32'(e.cout));
        check("Overflow", d, 32'(ovf_a[d]), 32'(e.ovf));
        @(negedge clk);
        check("done_one_cycle", d, 32'(done_a[d]), 32'd0);
    endtask

    // Start held high through DONE: second operation accepted straight from DONE.
    task automatic b2b(input int d, input logic [15:0] x1, input logic [15:0] y1,
                       input logic [15:0] x2, input logic [15:0] y2, input logic cin2);
        res_t e1, e2;
        int first = -1;
        int second = -1;
        e1 = model(1'b0, 1'b0, x1, y1);
        e2 = model(1'b0, cin2, x2, y2);
        @(negedge clk);
        sub_v[d] = 1'b0; cin_v[d] = 1'b0; x_v[d] = x1; y_v[d] = y1; start_v[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        x_v[d] = x2; y_v[d] = y2; cin_v[d] = cin2;
        for (int m = 0; m < 200; m++) begin
            if (done_a[d]) begin
                if (first < 0) begin
                    first = m;
                    check("b2b_S1", d, 32'(s_a[d]), 32'(e1.s));
                    check("b2b_Cout1", d, 32'(cout_a[d]), 32'(e1.cout));
                end else begin
                    second = m;
                    check("b2b_S2", d, 32'(s_a[d]), 32'(e2.s));
                    check("b2b_Cout2", d, 32'(cout_a[d]), 32'(e2.cout));
                    check("b2b_Ovf2", d, 32'(ovf_a[d]), 32'(e2.ovf));
                    break;
                end
            end
            if (m == nd[d] + 1) begin
                check("b2b_rerun_busy", d, 32'(busy_a[d]), 32'd1);
                start_v[d] = 1'b0;
            end
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        check("b2b_first_at", d, 32'(first), 32'(nd[d]));
        check("b2b_gap", d, 32'(second - first), 32'(nd[d] + 1));
    endtask

    initial begin
        vec_t tbl [5];
        int   pulses;
        res_t e;
        tbl[0] = '{sub: 1'b0, cin: 1'b0, x: 16'h1234, y: 16'h4321, s: 16'h5555, cout: 1'b0, ovf: 1'b0};
        tbl[1] = '{sub: 1'b0, cin: 1'b0, x: 16'hFFFF, y: 16'h0001, s: 16'h0000, cout: 1'b1, ovf: 1'b0};
        tbl[2] = '{sub: 1'b0, cin: 1'b1, x: 16'h7FFF, y: 16'h0000, s: 16'h8000, cout: 1'b0, ovf: 1'b1};
        tbl[3] = '{sub: 1'b1, cin: 1'b0, x: 16'h0005, y: 16'h0007, s: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
        tbl[4] = '{sub: 1'b1, cin: 1'b1, x: 16'h8000, y: 16'h0001, s: 16'h7FFF, cout: 1'b1, ovf: 1'b1};

        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b1; start_v[d] = 1'b0; sub_v[d] = 1'b0; cin_v[d] = 1'b0;
            x_v[d] = 16'h0000; y_v[d] = 16'h0000;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            rst_v[d] = 1'b0;
            check("rst_S", d, 32'(s_a[d]), 32'd0);
            check("rst_busy", d, 32'(busy_a[d]), 32'd0);
            check("rst_done", d, 32'(done_a[d]), 32'd0);
            check("rst_cout_ovf", d, 32'({cout_a[d], ovf_a[d]}), 32'd0);
        end

        for (int i = 0; i < 5; i++) begin
            e = '{s: tbl[i].s, cout: tbl[i].cout, ovf: tbl[i].ovf};
            do_op(0, tbl[i].sub, tbl[i].cin, tbl[i].x, tbl[i].y, 1'b0, e);
        end

        e = model(1'b0, 1'b0, 16'h0F0F, 16'h1111);
        do_op(0, 1'b0, 1'b0, 16'h0F0F, 16'h1111, 1'b1, e);

        // Reset on the second RUN cycle aborts the operation
        do_op(0, 1'b0, 1'b0, 16'h1234, 16'h4321, 1'b0, '{s: 16'h5555, cout: 1'b0, ovf: 1'b0});
        @(negedge clk);
        x_v[0] = 16'hAAAA; y_v[0] = 16'h1111; start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("abort_busy", 0, 32'(busy_a[0]), 32'd0);
        check("abort_S", 0, 32'(s_a[0]), 32'd0);
        check("abort_done", 0, 32'(done_a[0]), 32'd0);
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_a[0]) pulses++;
        end
        check("abort_no_done", 0, 32'(pulses), 32'd0);
        do_op(0, 1'b1, 1'b0, 16'h0005, 16'h0007, 1'b0, '{s: 16'hFFFE, cout: 1'b0, ovf: 1'b0});

        for (int d = 0; d < 3; d++) begin
            b2b(d, 16'h1234, 16'h4321, 16'h7FFF, 16'h0000, 1'b1);
            for (int i = 0; i < 12; i++) begin
                logic        rs, rc;
                logic [15:0] rx, ry;
                rs = 1'($urandom_range(1, 0));
                rc = 1'($urandom_range(1, 0));
                rx = 16'($urandom);
                ry = 16'($urandom);
                if (i == 0) begin rx = 16'hFFFF; ry = 16'hFFFF; end
                if (i == 1) begin rx = 16'h8000; ry = 16'h8000; end
                e = model(rs, rc, rx, ry);
                do_op(d, rs, rc, rx, ry, (i % 3) == 2, e);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
